// File: rtl/spi_slave.sv
// spi_slave -- SPI mode 0 responder (CPOL=0, CPHA=0, MSB first, 8-bit frames).
//
// SCLK, SS_n and MOSI are oversampled in the clk domain through SYNC_STAGES
// flops. Edges of the synchronised SCLK/SS_n are registered as one-cycle pulses.
// The FSM consumes those pulses. Back-to-back bytes are supported while SS_n
// stays low.
//
// Build option: define SPI_SLAVE_MISO_TRISTATE_EN to release miso (1'bz)
// while deselected. Otherwise miso is driven 0 while deselected.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   sclk/ss_n/mosi   asynchronous SPI pins from the master
//   miso         serial data out (TX shift register bit 7 while busy)
//   tx_data/tx_valid/tx_ready   one-byte TX holding buffer, ready/valid handshake
//   rx_data      last completed received byte
//   rx_valid     one-cycle strobe when rx_data is updated
//   busy         synchronised ss_n is low
//   tx_underrun  one-cycle pulse when IDLE_BYTE was loaded because the buffer was empty
//   frame_err    one-cycle pulse when ss_n rose mid-byte
//
// State | meaning
// IDLE  | deselected, waiting for ss_n to fall
// LOAD  | one cycle: fill the TX shift register from the buffer or IDLE_BYTE
// SHIFT | clocking bits on sclk edges
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       tx_underrun,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_d, ss_d;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
    state_t     state;
    logic [7:0] tx_shift, rx_shift, tx_buf;
    logic       tx_full;
    logic [2:0] bit_cnt;
    logic       reload;
    logic       load_req, accept;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // ss_n chain resets high so the bus looks deselected coming out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            ss_rise   <= ss_s & ~ss_d;
            ss_fall   <= ~ss_s & ss_d;
            busy      <= ~ss_s;
        end
    end

    assign tx_ready = ~tx_full;
    assign accept   = tx_valid & ~tx_full;

    // A load happens in LOAD, or on the sclk fall that follows a completed byte.
    always_comb begin
        load_req = 1'b0;
        if (!ss_rise) begin
            if (state == LOAD)
                load_req = 1'b1;
            else if (state == SHIFT && sclk_fall && reload)
                load_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            bit_cnt     <= '0;
            reload      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (accept) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            // The buffer is checked before this cycle's accept, so a byte
            // arriving together with a load goes to the buffer, not the wire.
            if (load_req) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    tx_full  <= 1'b0;
                end else begin
                    tx_shift    <= IDLE_BYTE;
                    tx_underrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ss_fall)
                        state <= LOAD;
                end
                LOAD: begin
                    bit_cnt <= '0;
                    reload  <= 1'b0;
                    state   <= ss_rise ? IDLE : SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {rx_shift[6:0], mosi_s};
                            rx_valid <= 1'b1;
                            reload   <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (reload)
                            reload <= 1'b0;
                        else
                            tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                    if (ss_rise) begin
                        // A byte finishing in the same cycle is delivered, not an error.
                        if (bit_cnt != 3'd0 && !(sclk_rise && bit_cnt == 3'd7))
                            frame_err <= 1'b1;
                        bit_cnt  <= '0;
                        reload   <= 1'b0;
                        rx_shift <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = busy ? tx_shift[7] : 1'bz;
`else
    assign miso = busy ? tx_shift[7] : 1'b0;
`endif

endmodule
